// File: rtl/csi_rx_byte_align.sv
// Per-lane HS byte aligner: hunts for the SoT sync byte at any of 8 bit offsets in the
// raw deserialiser stream, then locks and emits aligned payload bytes until gap or end of packet.
module csi_rx_byte_align #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned GAP_MAX      = 4,
  parameter int unsigned HUNT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_valid,
  input  logic [7:0] din,
  input  logic       pkt_done,
  output logic       dout_valid,
  output logic [7:0] dout,
  output logic       locked,
  output logic [2:0] offset,
  output logic       sync_found,
  output logic       sync_err,
  output logic       dbg_state
);

  // Valid-only streaming: din_valid and dout_valid are one-cycle qualifiers with no
  // backpressure; a byte is consumed on every rising edge where din_valid is high.

  localparam int unsigned GAP_W  = $clog2(GAP_MAX + 2);
  localparam int unsigned HUNT_W = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX);
  localparam logic [HUNT_W-1:0] HUNT_LAST = HUNT_W'(HUNT_TIMEOUT - 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          prev_q, prev_d;
  logic [2:0]          offset_q, offset_d;
  logic [7:0]          dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sync_found_q, sync_found_d;
  logic                sync_err_q, sync_err_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [HUNT_W-1:0]   hunt_q, hunt_d;

  logic [15:0]         win;
  logic [15:0]         win_shift;
  logic [7:0]          aligned;
  logic [7:0]          low_zero;
  logic [7:0]          cand_hit;
  logic                hit_any;
  logic [2:0]          hit_k;

  // low_zero[k] is the HS-zero precondition: every window bit below candidate k is 0.
  always_comb begin
    win         = {din, prev_q};
    low_zero    = '0;
    cand_hit    = '0;
    low_zero[0] = 1'b1;
    for (int k = 1; k < 8; k++) begin
      low_zero[k] = low_zero[k-1] & ~win[k-1];
    end
    for (int k = 0; k < 8; k++) begin
      cand_hit[k] = low_zero[k] && (win[k +: 8] == SYNC_BYTE);
    end
  end

  // Lowest matching offset wins, so scan from the top down.
  always_comb begin
    hit_any = |cand_hit;
    hit_k   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (cand_hit[k]) begin
        hit_k = 3'(k);
      end
    end
  end

  assign win_shift = win >> offset_q;
  assign aligned   = win_shift[7:0];

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    offset_d     = offset_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_found_d = 1'b0;
    sync_err_d   = 1'b0;
    gap_d        = gap_q;
    hunt_d       = hunt_q;

    if (din_valid) begin
      prev_d = din;
    end

    case (state_q)
      ST_HUNT: begin
        gap_d = '0;
        if (din_valid) begin
          if (hit_any) begin
            state_d      = ST_LOCKED;
            offset_d     = hit_k;
            sync_found_d = 1'b1;
            hunt_d       = '0;
          end else if (din != 8'h00) begin
            if (hunt_q == HUNT_LAST) begin
              sync_err_d = 1'b1;
              hunt_d     = '0;
            end else begin
              hunt_d = hunt_q + HUNT_W'(1);
            end
          end
        end
      end

      ST_LOCKED: begin
        // End of packet outranks both a same-cycle byte and the gap rule.
        if (pkt_done) begin
          state_d = ST_HUNT;
          prev_d  = 8'hFF;
          hunt_d  = '0;
          gap_d   = '0;
        end else if (din_valid) begin
          dout_d       = aligned;
          dout_valid_d = 1'b1;
          gap_d        = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_HUNT;
          prev_d  = 8'hFF;
          hunt_d  = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_HUNT;
        prev_d  = 8'hFF;
        hunt_d  = '0;
        gap_d   = '0;
      end
    endcase
  end

  // prev resets to all-ones so reset can never leave zeros that fake the HS-zero precondition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      prev_q       <= 8'hFF;
      offset_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      sync_err_q   <= 1'b0;
      gap_q        <= '0;
      hunt_q       <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      offset_q     <= offset_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_found_q <= sync_found_d;
      sync_err_q   <= sync_err_d;
      gap_q        <= gap_d;
      hunt_q       <= hunt_d;
    end
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign locked     = (state_q == ST_LOCKED);
  assign offset     = offset_q;
  assign sync_found = sync_found_q;
  assign sync_err   = sync_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_csi_rx_byte_align.sv
// Self-checking bench for csi_rx_byte_align: scenario tasks plus an expected-byte queue
// that is drained whenever the aligner presents an output byte.
module tb_csi_rx_byte_align;

  logic       clk;
  logic       rst_n;
  logic       din_valid;
  logic [7:0] din;
  logic       pkt_done;
  logic       dout_valid;
  logic [7:0] dout;
  logic       locked;
  logic [2:0] offset;
  logic       sync_found;
  logic       sync_err;
  logic       dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         total_cnt = 0;
  int         pass_cnt  = 0;

  csi_rx_byte_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .pkt_done   (pkt_done),
    .dout_valid (dout_valid),
    .dout       (dout),
    .locked     (locked),
    .offset     (offset),
    .sync_found (sync_found),
    .sync_err   (sync_err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test sequence to finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every output byte must match the head of the expected queue.
  always @(posedge clk) begin
    #2;
    if (dout_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL dout_unexpected: got dout_valid with dout=%h, required no output", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) $display("FAIL dout_data: got %h, required %h", dout, mon_exp);
        else pass_cnt++;
      end
    end
  end

  // Driver: present one cycle of input, then return the inputs to idle.
  task automatic drive(input logic v, input logic [7:0] d, input logic pd);
    din_valid = v;
    din       = d;
    pkt_done  = pd;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 8'h00;
    pkt_done  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din_valid = 1'b0; din = 8'h00; pkt_done = 1'b0;
    #3;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %b, required 0", dout_valid); else pass_cnt++;
    total_cnt++; if (dout !== 8'h00) $display("FAIL rst_dout: got %h, required 00", dout); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b, required 0", locked); else pass_cnt++;
    total_cnt++; if (offset !== 3'd0) $display("FAIL rst_offset: got %0d, required 0", offset); else pass_cnt++;
    total_cnt++; if ({sync_found, sync_err} !== 2'b00) $display("FAIL rst_pulses: got %b, required 00", {sync_found, sync_err}); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (dbg_state !== 1'b0) $display("FAIL rst_state: got %b, required 0", dbg_state); else pass_cnt++;
  endtask

  task automatic test_offset0;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hB8, 1'b0);
    total_cnt++; if (sync_found !== 1'b0) $display("FAIL off0_early_sync: got %b, required 0", sync_found); else pass_cnt++;
    drive(1'b1, 8'h11, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL off0_sync: got %b, required 1", sync_found); else pass_cnt++;
    total_cnt++; if (offset !== 3'd0) $display("FAIL off0_offset: got %0d, required 0", offset); else pass_cnt++;
    total_cnt++; if (locked !== 1'b1) $display("FAIL off0_locked: got %b, required 1", locked); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL off0_no_sync_out: got %b, required 0", dout_valid); else pass_cnt++;
    exp_q.push_back(8'h11);
    drive(1'b1, 8'h22, 1'b0);
    total_cnt++; if (sync_found !== 1'b0) $display("FAIL off0_sync_pulse: got %b, required 0", sync_found); else pass_cnt++;
    exp_q.push_back(8'h22);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    total_cnt++; if (locked !== 1'b0) $display("FAIL off0_exit: got %b, required 0", locked); else pass_cnt++;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL off0_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
  endtask

  // Locks at offset 3, then exercises the idle-gap tolerance at and beyond its limit.
  task automatic test_offset3_gap;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hC0, 1'b0);
    drive(1'b1, 8'h8D, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL off3_sync: got %b, required 1", sync_found); else pass_cnt++;
    total_cnt++; if (offset !== 3'd3) $display("FAIL off3_offset: got %0d, required 3", offset); else pass_cnt++;
    exp_q.push_back(8'h11);
    drive(1'b1, 8'h10, 1'b0);
    exp_q.push_back(8'h22);
    drive(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL gap4_locked: got %b, required 1", locked); else pass_cnt++;
    total_cnt++; if (dout !== 8'h22) $display("FAIL gap4_dout_hold: got %h, required 22", dout); else pass_cnt++;
    exp_q.push_back(8'hA0);
    drive(1'b1, 8'h35, 1'b0);
    total_cnt++; if (dout_valid !== 1'b1) $display("FAIL gap4_resume: got %b, required 1", dout_valid); else pass_cnt++;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (locked !== 1'b1) $display("FAIL gap5_pre: got %b, required 1", locked); else pass_cnt++;
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (locked !== 1'b0) $display("FAIL gap5_drop: got %b, required 0", locked); else pass_cnt++;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    total_cnt++; if (sync_found !== 1'b0) $display("FAIL gap5_no_sync: got %b, required 0", sync_found); else pass_cnt++;
    total_cnt++; if (offset !== 3'd3) $display("FAIL gap5_offset_hold: got %0d, required 3", offset); else pass_cnt++;
  endtask

  task automatic test_pkt_done;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hB8, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL pkt_lock_sync: got %b, required 1", sync_found); else pass_cnt++;
    exp_q.push_back(8'h44);
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b1, 8'h33, 1'b1);
    total_cnt++; if (locked !== 1'b0) $display("FAIL pkt_done_locked: got %b, required 0", locked); else pass_cnt++;
    total_cnt++; if (dout_valid !== 1'b0) $display("FAIL pkt_done_discard: got %b, required 0", dout_valid); else pass_cnt++;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hB8, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL pkt_relock_sync: got %b, required 1", sync_found); else pass_cnt++;
    total_cnt++; if (offset !== 3'd0) $display("FAIL pkt_relock_offset: got %0d, required 0", offset); else pass_cnt++;
    exp_q.push_back(8'h44);
    drive(1'b1, 8'h99, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    total_cnt++; if (locked !== 1'b0) $display("FAIL pkt_exit: got %b, required 0", locked); else pass_cnt++;
  endtask

  // Hunt timeout: 16 non-zero bytes pulse the error; HS-zero bytes never advance the count.
  task automatic test_timeout;
    int bad;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'h55, 1'b0);
      if (sync_err !== (i == 16)) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL timeout16: got %0d wrong sync_err samples, required 0", bad); else pass_cnt++;
    drive(1'b1, 8'h55, 1'b0);
    total_cnt++; if (sync_err !== 1'b0) $display("FAIL timeout_pulse: got %b, required 0", sync_err); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 8'h00, 1'b0);
      if (sync_err !== 1'b0 || sync_found !== 1'b0) bad++;
      drive(1'b1, 8'h55, 1'b0);
      if (sync_err !== 1'b0 || sync_found !== 1'b0) bad++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 1'b0);
      if (sync_err !== 1'b0) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL timeout_zeros: got %0d early pulses, required 0", bad); else pass_cnt++;
    drive(1'b1, 8'h55, 1'b0);
    total_cnt++; if (sync_err !== 1'b1) $display("FAIL timeout_wrap: got %b, required 1", sync_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hB8, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL rmid_sync: got %b, required 1", sync_found); else pass_cnt++;
    exp_q.push_back(8'h44);
    drive(1'b1, 8'h12, 1'b0);
    din_valid = 1'b1;
    din       = 8'h34;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({dout_valid, dout, locked, offset, sync_found, sync_err} !== 14'h0)
      $display("FAIL rmid_async: got %h, required 0000", {dout_valid, dout, locked, offset, sync_found, sync_err});
    else pass_cnt++;
    din_valid = 1'b0;
    din       = 8'h00;
    @(posedge clk); #3;
    rst_n = 1'b1;
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'hB8, 1'b0);
    total_cnt++; if ({dout_valid, sync_found} !== 2'b00) $display("FAIL rrel_quiet: got %b, required 00", {dout_valid, sync_found}); else pass_cnt++;
    drive(1'b1, 8'h66, 1'b0);
    total_cnt++; if (sync_found !== 1'b1) $display("FAIL rrel_sync: got %b, required 1", sync_found); else pass_cnt++;
    exp_q.push_back(8'h66);
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
  endtask

  // Sync at every offset k, payload bit-packed right behind the sync byte; the aligned
  // output must reproduce the payload bytes exactly.
  task automatic test_back_to_back;
    logic [127:0] s;
    logic [7:0]   pay[8];
    logic [7:0]   b;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
      s = 128'(8'hB8) << (8 + k);
      for (int i = 0; i < 8; i++) s = s | (128'(pay[i]) << (16 + k + 8 * i));
      for (int j = 0; j < 11; j++) begin
        if (j >= 3) exp_q.push_back(pay[j-3]);
        b = s[8*j +: 8];
        drive(1'b1, b, 1'b0);
        if (j == 1) begin
          total_cnt++; if (sync_found !== 1'b0) $display("FAIL b2b_early_k%0d: got %b, required 0", k, sync_found); else pass_cnt++;
        end
        if (j == 2) begin
          total_cnt++; if (sync_found !== 1'b1) $display("FAIL b2b_sync_k%0d: got %b, required 1", k, sync_found); else pass_cnt++;
          total_cnt++; if (offset !== 3'(k)) $display("FAIL b2b_offset_k%0d: got %0d, required %0d", k, offset, k); else pass_cnt++;
        end
      end
      drive(1'b0, 8'h00, 1'b1);
      total_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_drain_k%0d: got %0d pending, required 0", k, exp_q.size()); else pass_cnt++;
    end
  endtask

  task automatic test_false_match;
    int bad;
    bad = 0;
    drive(1'b1, 8'h00, 1'b0);
    if (sync_found !== 1'b0) bad++;
    drive(1'b1, 8'hFF, 1'b0);
    if (sync_found !== 1'b0) bad++;
    drive(1'b1, 8'hB8, 1'b0);
    if (sync_found !== 1'b0) bad++;
    drive(1'b0, 8'h00, 1'b0);
    if (sync_found !== 1'b0) bad++;
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bad != 0) $display("FAIL false_match: got %0d sync pulses, required 0", bad); else pass_cnt++;
    total_cnt++; if (locked !== 1'b0) $display("FAIL false_match_locked: got %b, required 0", locked); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_offset0();
    test_offset3_gap();
    test_pkt_done();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_false_match();
    repeat (2) @(posedge clk);
    #3;
    total_cnt++; if (exp_q.size() != 0) $display("FAIL final_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
